alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Self-checking response monitor for the 4-bit ALU: samples each applied operand/opcode/result tuple, recomputes the expected result, counts checks, passes and failures, and captures the first mismatch.
- Sits at the ALU output alongside the stimulus driver, so benches and on-board tests get a pass/fail verdict without manually comparing waveforms.
- The ALU is combinational, so result is compared in the same cycle its operands are sampled.

Parameters:
- CNT_W, 8, width of check/pass/fail/skip counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new run; clears counters and capture
- end_run  input  1  close the current run and produce the verdict
- in_valid  input  1  A/B/op_sel/result are valid this cycle
- A  input  4  ALU operand A
- B  input  4  ALU operand B
- op_sel  input  2  ALU opcode: 00 ADD, 01 AND, 10/11 unsupported
- result  input  4  ALU result under test
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  valid while done: fail_cnt==0 and check_cnt>0
- err  output  1  one-cycle pulse, the cycle after a mismatching sample
- check_cnt  output  CNT_W  compared samples
- fail_cnt  output  CNT_W  mismatching samples
- skip_cnt  output  CNT_W  samples with unsupported opcode
- fail_valid  output  1  a first failure has been captured
- fail_A  output  4  A of first failure
- fail_B  output  4  B of first failure
- fail_op  output  2  op_sel of first failure
- fail_got  output  4  result of first failure
- fail_exp  output  4  expected value of first failure

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output 0, including all counters and capture fields. Deassertion takes effect at the next clk edge.
- Expected value:
  - 00 → (A+B) mod 16; carry discarded, so 12+4 gives 0.
  - 01 → A & B.
  - 10/11 → not compared; skip_cnt increments.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN; counters and capture cleared on that edge. in_valid and end_run ignored.
  - RUN: busy=1. Each clk edge with in_valid=1 and a supported opcode:
    - check_cnt+1.
    - If result != expected: fail_cnt+1 and err=1 on the next cycle.
    - If fail_valid=0: latch the fail_* fields and set fail_valid=1. Later failures never overwrite the capture.
  - RUN, end_run=1 → DONE. A sample with in_valid on the same edge is still counted. pass is evaluated from the counts including that sample.
  - RUN, start=1 (end_run=0) → restart: counters and capture cleared and state stays RUN; a sample on that edge is discarded.
  - Simultaneous start and end_run in RUN: end_run wins.
  - DONE: done=1; pass, counters and capture hold. in_valid ignored. start → RUN with clear, as from IDLE.
- Counters: saturate at all-ones and never wrap. Saturation of check_cnt does not stop fail detection or err pulses.
- err: registered, high exactly one cycle per mismatching sample. Back-to-back mismatches keep it high continuously.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No verdict is retained.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, start, then in_valid with A=12,B=4,op=00,result=0; A=15,B=10,op=01,result=10; A=5,B=3,op=00,result=8; A=5,B=3,op=01,result=1; A=12,B=3,op=01,result=0; then end_run → done=1, pass=1, check_cnt=5, fail_cnt=0, err never high.
- Run with A=5,B=3,op=00,result=7, then A=1,B=1,op=01,result=0 → err pulses in both following cycles; fail_cnt=2; fail_A=5, fail_B=3, fail_op=00, fail_got=7, fail_exp=8; after end_run, pass=0.
- Samples with op=10 and op=11 → skip_cnt=2, check_cnt=0; end_run → pass=0 because there were no checks.
- CNT_W=3 with 10 passing samples → check_cnt holds at 7; then one bad sample → fail_cnt=1, err pulses.
- rst_n low mid-run after 3 samples, with one of them failing → all outputs 0 immediately, without waiting for clk; state IDLE; in_valid ignored until start.
- Same edge carries in_valid (a good sample) and end_run → sample counted. Separately, start in DONE clears every counter and capture field and sets busy=1.

Source files
------------

// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if
//   Sample bus between the ALU stimulus driver and the result checker.
//   One tuple (A, B, op_sel, result) is presented per cycle, qualified by
//   in_valid.
//
//   Signals:
//     in_valid : tuple below is valid this cycle
//     A, B     : 4-bit ALU operands
//     op_sel   : ALU opcode (00 ADD, 01 AND, 10/11 unsupported)
//     result   : ALU output under test
//
//   Modports:
//     master : stimulus side, drives the tuple
//     slave  : checker side, observes the tuple
interface alu_result_checker_if;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] op_sel;
    logic [3:0] result;

    modport master (
        output in_valid,
        output A,
        output B,
        output op_sel,
        output result
    );

    modport slave (
        input in_valid,
        input A,
        input B,
        input op_sel,
        input result
    );
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Response monitor for the 4-bit ALU. Each valid sample is checked against
//   a recomputed expected value in the same cycle it is sampled (the ALU is
//   combinational). Counts checks, failures and skipped (unsupported opcode)
//   samples, captures the first failing tuple, and produces a pass/fail
//   verdict when a run is closed.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     smp         : sample bus (in_valid, A, B, op_sel, result), slave side
//     start       : open a new run, clearing counters and capture
//     end_run     : close the run and produce the verdict
//     busy, done  : state flags (RUN / DONE)
//     pass        : verdict, valid while done
//     err         : one-cycle pulse after each mismatching sample
//     check_cnt   : compared samples      (saturating)
//     fail_cnt    : mismatching samples   (saturating)
//     skip_cnt    : unsupported samples   (saturating)
//     fail_valid  : first failure captured
//     fail_A/B/op/got/exp : first failing tuple and its expected value
module alu_result_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_checker_if.slave  smp,
    input  logic                 start,
    input  logic                 end_run,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 err,
    output logic [CNT_W-1:0]     check_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     skip_cnt,
    output logic                 fail_valid,
    output logic [3:0]           fail_A,
    output logic [3:0]           fail_B,
    output logic [1:0]           fail_op,
    output logic [3:0]           fail_got,
    output logic [3:0]           fail_exp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [3:0]       exp_val;
    logic             cmp_en;
    logic             skip_en;
    logic             mismatch;
    logic [CNT_W-1:0] check_nxt;
    logic [CNT_W-1:0] fail_nxt;
    logic [CNT_W-1:0] skip_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Expected value and the counter values this sample would produce.
    // Only applied in RUN; the sequential block decides whether to commit.
    always_comb begin
        exp_val = '0;
        case (smp.op_sel)
            2'b00:   exp_val = smp.A + smp.B;   // carry dropped, mod 16
            2'b01:   exp_val = smp.A & smp.B;
            default: exp_val = '0;
        endcase

        cmp_en    = smp.in_valid && !smp.op_sel[1];
        skip_en   = smp.in_valid &&  smp.op_sel[1];
        mismatch  = cmp_en && (smp.result != exp_val);

        check_nxt = cmp_en   ? sat_inc(check_cnt) : check_cnt;
        fail_nxt  = mismatch ? sat_inc(fail_cnt)  : fail_cnt;
        skip_nxt  = skip_en  ? sat_inc(skip_cnt)  : skip_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= 1'b0;
            check_cnt  <= '0;
            fail_cnt   <= '0;
            skip_cnt   <= '0;
            fail_valid <= 1'b0;
            fail_A     <= '0;
            fail_B     <= '0;
            fail_op    <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        check_cnt  <= '0;
                        fail_cnt   <= '0;
                        skip_cnt   <= '0;
                        fail_valid <= 1'b0;
                        fail_A     <= '0;
                        fail_B     <= '0;
                        fail_op    <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                    end
                end

                RUN: begin
                    if (start && !end_run) begin
                        // Restart: any sample on this edge is discarded.
                        check_cnt  <= '0;
                        fail_cnt   <= '0;
                        skip_cnt   <= '0;
                        fail_valid <= 1'b0;
                        fail_A     <= '0;
                        fail_B     <= '0;
                        fail_op    <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                    end else begin
                        check_cnt <= check_nxt;
                        fail_cnt  <= fail_nxt;
                        skip_cnt  <= skip_nxt;
                        if (mismatch) begin
                            err <= 1'b1;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_A     <= smp.A;
                                fail_B     <= smp.B;
                                fail_op    <= smp.op_sel;
                                fail_got   <= smp.result;
                                fail_exp   <= exp_val;
                            end
                        end
                        if (end_run) begin
                            // Verdict includes a sample taken on this same edge.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_nxt == '0) && (check_nxt != '0);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

    logic clk;
    logic rst_n;
    logic start;
    logic end_run;

    int unsigned n_checks;
    int unsigned n_errors;

    alu_result_checker_if bus ();

    // Main instance (CNT_W = 8)
    logic       busy, done, pass, err, fail_valid;
    logic [7:0] check_cnt, fail_cnt, skip_cnt;
    logic [3:0] fail_A, fail_B, fail_got, fail_exp;
    logic [1:0] fail_op;

    // Narrow-counter instance (CNT_W = 3) for saturation
    logic       busy3, done3, pass3, err3, fail_valid3;
    logic [2:0] check_cnt3, fail_cnt3, skip_cnt3;
    logic [3:0] fail_A3, fail_B3, fail_got3, fail_exp3;
    logic [1:0] fail_op3;

    alu_result_checker #(.CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .smp        (bus.slave),
        .start      (start),
        .end_run    (end_run),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err        (err),
        .check_cnt  (check_cnt),
        .fail_cnt   (fail_cnt),
        .skip_cnt   (skip_cnt),
        .fail_valid (fail_valid),
        .fail_A     (fail_A),
        .fail_B     (fail_B),
        .fail_op    (fail_op),
        .fail_got   (fail_got),
        .fail_exp   (fail_exp)
    );

    alu_result_checker #(.CNT_W(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .smp        (bus.slave),
        .start      (start),
        .end_run    (end_run),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .err        (err3),
        .check_cnt  (check_cnt3),
        .fail_cnt   (fail_cnt3),
        .skip_cnt   (skip_cnt3),
        .fail_valid (fail_valid3),
        .fail_A     (fail_A3),
        .fail_B     (fail_B3),
        .fail_op    (fail_op3),
        .fail_got   (fail_got3),
        .fail_exp   (fail_exp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 ns after the
    // following rising edge so registered outputs can be sampled.
    task automatic cyc(input logic st, input logic er, input logic iv,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] r);
        @(negedge clk);
        start        = st;
        end_run      = er;
        bus.in_valid = iv;
        bus.A        = a;
        bus.B        = b;
        bus.op_sel   = op;
        bus.result   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
    endtask

    task automatic sample(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [3:0] r,
                          input logic exp_err, input string tag);
        cyc(1'b0, 1'b0, 1'b1, a, b, op, r);
        check(tag, err, exp_err);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        end_run      = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.op_sel   = '0;
        bus.result   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_check_cnt", check_cnt, 0);
        check("rst_fail_valid", fail_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores samples and end_run
        cyc(1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 2'd0, 4'd7);
        check("idle_ign_busy", busy, 0);
        check("idle_ign_check", check_cnt, 0);
        check("idle_ign_fail", fail_cnt, 0);

        // Run 1: all samples correct, including the ADD carry wrap
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t1_busy", busy, 1);
        sample(4'd12, 4'd4,  2'b00, 4'd0,  1'b0, "t1_err_add_wrap");
        sample(4'd15, 4'd10, 2'b01, 4'd10, 1'b0, "t1_err_and");
        sample(4'd5,  4'd3,  2'b00, 4'd8,  1'b0, "t1_err_add");
        sample(4'd5,  4'd3,  2'b01, 4'd1,  1'b0, "t1_err_and2");
        sample(4'd12, 4'd3,  2'b01, 4'd0,  1'b0, "t1_err_and0");
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_check_cnt", check_cnt, 5);
        check("t1_fail_cnt", fail_cnt, 0);
        check("t1_fail_valid", fail_valid, 0);

        // Run 2: two mismatches back to back, first one captured
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t2_done_clr", done, 0);
        check("t2_pass_clr", pass, 0);
        check("t2_check_clr", check_cnt, 0);
        sample(4'd5, 4'd3, 2'b00, 4'd7, 1'b1, "t2_err1");
        sample(4'd1, 4'd1, 2'b01, 4'd0, 1'b1, "t2_err2");
        idle_cyc();
        check("t2_err_low", err, 0);
        check("t2_fail_cnt", fail_cnt, 2);
        check("t2_check_cnt", check_cnt, 2);
        check("t2_fail_valid", fail_valid, 1);
        check("t2_fail_A", fail_A, 5);
        check("t2_fail_B", fail_B, 3);
        check("t2_fail_op", fail_op, 0);
        check("t2_fail_got", fail_got, 7);
        check("t2_fail_exp", fail_exp, 8);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        // DONE ignores samples
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 2'b00, 4'd0);
        check("t2_done_ign_err", err, 0);
        check("t2_done_ign_fail", fail_cnt, 2);
        check("t2_done_hold_A", fail_A, 5);

        // Run 3: unsupported opcodes only
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        sample(4'd1, 4'd1, 2'b10, 4'd0, 1'b0, "t3_err_op10");
        sample(4'd1, 4'd1, 2'b11, 4'd9, 1'b0, "t3_err_op11");
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t3_skip_cnt", skip_cnt, 2);
        check("t3_check_cnt", check_cnt, 0);
        check("t3_done", done, 1);
        check("t3_pass", pass, 0);

        // Run 4: saturation on the 3-bit instance
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a;
            a = 4'(i);
            sample(a, 4'd1, 2'b00, 4'(a + 4'd1), 1'b0, "t4_err_good");
        end
        check("t4_check_cnt3_sat", check_cnt3, 7);
        check("t4_check_cnt8", check_cnt, 10);
        sample(4'd2, 4'd2, 2'b00, 4'd0, 1'b1, "t4_err_bad");
        check("t4_err3", err3, 1);
        check("t4_fail_cnt3", fail_cnt3, 1);
        check("t4_check_cnt3_hold", check_cnt3, 7);
        check("t4_fail_exp3", fail_exp3, 4);
        idle_cyc();
        check("t4_err3_low", err3, 0);

        // Run 5: start in RUN restarts and discards the sample on that edge
        cyc(1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 2'b00, 4'd0);
        check("t5_restart_busy", busy, 1);
        check("t5_restart_check", check_cnt, 0);
        check("t5_restart_fail", fail_cnt, 0);
        check("t5_restart_fvalid", fail_valid, 0);
        check("t5_restart_fexp", fail_exp, 0);
        check("t5_restart_err", err, 0);
        // start and end_run together: end_run wins, sample on that edge counted
        cyc(1'b1, 1'b1, 1'b1, 4'd3, 4'd4, 2'b00, 4'd7);
        check("t5_same_edge_done", done, 1);
        check("t5_same_edge_check", check_cnt, 1);
        check("t5_same_edge_pass", pass, 1);

        // Run 6: start from DONE after a captured failure clears everything
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        sample(4'd6, 4'd5, 2'b01, 4'd3, 1'b1, "t6_err_bad");
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t6_fail_valid", fail_valid, 1);
        check("t6_fail_exp", fail_exp, 4);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
        check("t6_clr_busy", busy, 1);
        check("t6_clr_done", done, 0);
        check("t6_clr_fail_cnt", fail_cnt, 0);
        check("t6_clr_fail_valid", fail_valid, 0);
        check("t6_clr_fail_A", fail_A, 0);
        check("t6_clr_fail_B", fail_B, 0);
        check("t6_clr_fail_got", fail_got, 0);
        check("t6_clr_fail_exp", fail_exp, 0);

        // Run 7: asynchronous reset mid-run
        sample(4'd1, 4'd2, 2'b00, 4'd3, 1'b0, "t7_err_g1");
        sample(4'd7, 4'd7, 2'b01, 4'd7, 1'b0, "t7_err_g2");
        sample(4'd8, 4'd8, 2'b00, 4'd1, 1'b1, "t7_err_bad");
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_err", err, 0);
        check("t7_rst_check", check_cnt, 0);
        check("t7_rst_fail", fail_cnt, 0);
        check("t7_rst_fvalid", fail_valid, 0);
        check("t7_rst_fexp", fail_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'd8, 4'd8, 2'b00, 4'd1);
        check("t7_idle_busy", busy, 0);
        check("t7_idle_check", check_cnt, 0);
        check("t7_idle_err", err, 0);
        idle_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
